fi_div_seq: RTL and testbench
=============================

Name: fi_div_seq

Overview:
- Multi-cycle signed fixed-point divider, computing c = (a << dp) / b on the fi_* word format (ws-bit two's complement, dp fraction bits).
- Inverse operation of the fixed-point multiplier. Replaces combinational division in timing-critical audio-effect paths (gain normalisation, envelope ratios).
- One quotient bit per cycle via restoring division on magnitudes.
- Valid/ready handshake on both sides; reports overflow and divide-by-zero.

Parameters:
ws, 16, total word width in bits (signed)
dp, 8, fraction bits; must satisfy 1 <= dp < ws
SAT, 0, overflow policy: 0 = wrap (keep low ws bits of the signed quotient), 1 = saturate to FI_MAX/FI_MIN

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  operands a, b are valid
in_ready  out  1  block can accept operands (high only in IDLE)
a  in  ws  dividend, signed fixed-point
b  in  ws  divisor, signed fixed-point
out_valid  out  1  result valid; held until accepted
out_ready  in  1  consumer accepts the result
c  out  ws  quotient, signed fixed-point
ovf  out  1  quotient did not fit in ws bits; valid with out_valid
dz  out  1  divisor was zero; valid with out_valid
busy  out  1  high in CALC and FIX

Behaviour:
- Reset (rst sampled high at an edge): state=IDLE; in_ready=1; out_valid=0; c=0; ovf=0; dz=0; busy=0. Reset aborts any operation mid-CALC or mid-DONE with no output.
- States are IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - An edge with in_valid=1 accepts the operation. It registers sa=a[ws-1], sb=b[ws-1], |a| and |b| as ws-bit unsigned values, and clears the step counter.
  - If b==0, go to DONE on that edge. Set dz=1, ovf=0, c=FI_MAX if a>=0 else FI_MIN.
  - Otherwise go to CALC.
- CALC:
  - Dividend register = |a| << dp, N = ws+dp bits; remainder register is ws+1 bits.
  - Each edge performs one restoring step, MSB first: rem = {rem, next dividend bit}; if rem >= |b|, subtract and shift in 1, else shift in 0.
  - After exactly N steps, go to FIX.
- FIX:
  - q = N-bit magnitude; neg = sa ^ sb (forced to 0 when q==0).
  - Fits if neg ? q <= 2^(ws-1) : q <= 2^(ws-1)-1; ovf = !fits.
  - Signed result r = neg ? -q : q, computed in N+1 bits.
  - c = fits ? r[ws-1:0] : (SAT ? (neg ? FI_MIN : FI_MAX) : r[ws-1:0]).
  - Go to DONE on the next edge.
- DONE:
  - out_valid=1. c, ovf and dz stay stable until an edge with out_ready=1, which returns the block to IDLE.
  - out_valid drops on that same edge. in_ready is high from the following cycle; no same-cycle re-accept.
- Latency from the accepting edge to the first out_valid=1 cycle: ws+dp+2 edges (26 for defaults). Divide-by-zero: 1 edge.
- Rounding: truncation toward zero, identical to Verilog signed '/' on the widened operands. When SAT=0 and no divide-by-zero, the result is bit-identical to the combinational divider.
- in_valid while busy or in DONE is ignored; in_ready=0 there and operands are not sampled.
- Operand edge cases:
  - |FI_MIN| = 2^(ws-1) is represented exactly by the unsigned ws-bit magnitude.
  - a=0 gives c=0, ovf=0, and c is never negative zero.

Decomposition:
- Shared include fixed_point_defs.vh holds:
  - default ws/dp;
  - FI_MAX = 2^(ws-1)-1 and FI_MIN = -2^(ws-1) as parameterised expressions;
  - the 2-bit state encoding (IDLE=0, CALC=1, FIX=2, DONE=3).
- One combinational sub-module, fi_div_step: inputs rem (ws+1 bits), next dividend bit and divisor; outputs the new remainder and the quotient bit.
- Sign/abs handling and the FSM stay in fi_div_seq.

Test Plan (ws=16, dp=8, SAT=0 unless stated):
- Basic: a=0x0300 (3.0), b=0x0200 (2.0), out_ready=1 -> c=0x0180, ovf=0, dz=0. out_valid first high 26 edges after the accept edge; busy high throughout.
- Signs and truncation:
  - a=0xFD00, b=0x0200 -> 0xFE80.
  - a=0x0100, b=0x0300 -> 0x0055.
  - a=0xFF00, b=0x0300 -> 0xFFAB.
  - a=0x0000, b=0xFF00 -> 0x0000.
- Overflow:
  - a=0x7F00, b=0x0080 -> ovf=1. c=0xFE00 with SAT=0; c=0x7FFF with SAT=1.
  - a=0x8000, b=0xFF00 -> ovf=1. c=0x8000 with SAT=0; c=0x7FFF with SAT=1.
  - a=0x8000, b=0x0100 -> c=0x8000, ovf=0.
- Divide-by-zero:
  - a=0x0100, b=0 -> dz=1, c=0x7FFF, out_valid after 1 edge.
  - a=0xFF00, b=0 -> c=0x8000.
- Handshake:
  - Hold out_ready=0 for 10 cycles in DONE -> c/ovf/dz/out_valid stable, in_ready=0.
  - Pulse in_valid with new operands during CALC -> ignored; the result matches the first operands.
- Reset mid-operation: rst=1 for one edge at CALC step 10 -> next cycle in_ready=1, out_valid=0, c=0, busy=0. A subsequent operation with 0x0300/0x0200 produces 0x0180.

Source files
------------

// File: rtl/fi_div_seq_pkg.sv
// Shared definitions for the sequential fixed-point divider: default word format and FSM encoding.
package fi_div_seq_pkg;

    localparam int unsigned WS_DEF = 16;
    localparam int unsigned DP_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/fi_div_seq_if.sv
// Operand/result handshake bundle between a producer/consumer and the divider.
interface fi_div_seq_if import fi_div_seq_pkg::*; #(
    parameter int unsigned ws = WS_DEF
);
    logic          in_valid;
    logic          in_ready;
    logic [ws-1:0] a;
    logic [ws-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [ws-1:0] c;
    logic          ovf;
    logic          dz;
    logic          busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, ovf, dz, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, ovf, dz, busy
    );
endinterface

// File: rtl/fi_div_seq_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor when it fits.
module fi_div_step #(
    parameter int unsigned ws = 16
) (
    input  logic [ws:0]   rem_c_i,
    input  logic          bit_c_i,
    input  logic [ws-1:0] div_c_i,
    output logic [ws:0]   rem_c,
    output logic          q_c
);
    localparam int unsigned SW = ws + 2;
    localparam int unsigned RW = ws + 1;

    logic [SW-1:0] sh_c;
    logic [SW-1:0] diff_c;

    always_comb begin
        sh_c   = {rem_c_i, bit_c_i};
        diff_c = sh_c - SW'(div_c_i);
        q_c    = (sh_c >= SW'(div_c_i));
        rem_c  = q_c ? RW'(diff_c) : RW'(sh_c);
    end
endmodule

// File: rtl/fi_div_seq.sv
// Multi-cycle signed fixed-point divider c = (a << dp) / b, one quotient bit per cycle on magnitudes.
module fi_div_seq import fi_div_seq_pkg::*; #(
    parameter int unsigned ws  = WS_DEF,
    parameter int unsigned dp  = DP_DEF,
    parameter bit          SAT = 1'b0
) (
    input logic         clk,
    input logic         rst,
    fi_div_seq_if.slave bus
);
    localparam int unsigned N  = ws + dp;
    localparam int unsigned NW = N + 1;
    localparam int unsigned RW = ws + 1;
    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [ws-1:0] FI_MAX = {1'b0, {(ws-1){1'b1}}};
    localparam logic [ws-1:0] FI_MIN = {1'b1, {(ws-1){1'b0}}};
    localparam logic [NW-1:0] Q_LIM  = NW'(1) << (ws - 1);

    state_e        state_q, state_d;
    logic          sa_q, sa_d, sb_q, sb_d;
    logic [ws-1:0] mag_b_q, mag_b_d;
    logic [N-1:0]  dvd_q, dvd_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [ws-1:0] c_q, c_d;
    logic          ovf_q, ovf_d, dz_q, dz_d;
    logic          in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;

    logic [ws-1:0] mag_a_c, mag_b_c;
    logic [RW-1:0] step_rem_c;
    logic          step_q_c;
    logic [NW-1:0] q_ext_c, r_c;
    logic          neg_c, fits_c;
    logic [ws-1:0] res_c;

    assign mag_a_c = bus.a[ws-1] ? (~bus.a + ws'(1)) : bus.a;
    assign mag_b_c = bus.b[ws-1] ? (~bus.b + ws'(1)) : bus.b;

    fi_div_step #(.ws(ws)) u_step (
        .rem_c_i (rem_q),
        .bit_c_i (dvd_q[N-1]),
        .div_c_i (mag_b_q),
        .rem_c   (step_rem_c),
        .q_c     (step_q_c)
    );

    // Sign restoration and range check of the magnitude quotient
    always_comb begin
        q_ext_c = {1'b0, quo_q};
        neg_c   = (sa_q ^ sb_q) && (quo_q != '0);
        fits_c  = neg_c ? (q_ext_c <= Q_LIM) : (q_ext_c < Q_LIM);
        r_c     = neg_c ? (~q_ext_c + NW'(1)) : q_ext_c;
        res_c   = ws'(r_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            mag_b_q     <= '0;
            dvd_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            c_q         <= '0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            mag_b_q     <= mag_b_d;
            dvd_q       <= dvd_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            c_q         <= c_d;
            ovf_q       <= ovf_d;
            dz_q        <= dz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.in_valid) state_d = (bus.b == '0) ? ST_DONE : ST_CALC;
            ST_CALC: if (cnt_q == CW'(N - 1)) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sa_d    = sa_q;
        sb_d    = sb_q;
        mag_b_d = mag_b_q;
        dvd_d   = dvd_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    sa_d    = bus.a[ws-1];
                    sb_d    = bus.b[ws-1];
                    mag_b_d = mag_b_c;
                    dvd_d   = {mag_a_c, {dp{1'b0}}};
                    quo_d   = '0;
                    rem_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    dz_d    = (bus.b == '0);
                    // Divide-by-zero saturates toward the dividend's sign
                    if (bus.b == '0) c_d = bus.a[ws-1] ? FI_MIN : FI_MAX;
                end
            end
            ST_CALC: begin
                rem_d = step_rem_c;
                quo_d = {quo_q[N-2:0], step_q_c};
                dvd_d = dvd_q << 1;
                cnt_d = cnt_q + CW'(1);
            end
            ST_FIX: begin
                ovf_d = !fits_c;
                dz_d  = 1'b0;
                c_d   = (fits_c || !SAT) ? res_c : (neg_c ? FI_MIN : FI_MAX);
            end
            default: ;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d == ST_CALC) || (state_d == ST_FIX);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.c         = c_q;
    assign bus.ovf       = ovf_q;
    assign bus.dz        = dz_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_fi_div_seq.sv
// Bench for fi_div_seq: wrap and saturate instances driven in lockstep, checked against an arithmetic model.
module tb_fi_div_seq;
    localparam int unsigned WS  = 16;
    localparam int unsigned DP  = 8;
    localparam int          LAT = 26;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fi_div_seq_if #(.ws(WS)) bus0 ();
    fi_div_seq_if #(.ws(WS)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.a         = a_in;
    assign bus0.b         = b_in;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.a         = a_in;
    assign bus1.b         = b_in;
    assign bus1.out_ready = out_ready;

    fi_div_seq #(.ws(WS), .dp(DP), .SAT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    fi_div_seq #(.ws(WS), .dp(DP), .SAT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Returns {c, ovf, dz} from integer division of the widened operands
    function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv, input bit sat);
        longint n, d, q;
        logic [15:0] cr;
        logic o;
        if (bv == 16'h0000) return {(av[15] ? 16'h8000 : 16'h7FFF), 1'b0, 1'b1};
        n = longint'($signed(av)) * 256;
        d = longint'($signed(bv));
        q = n / d;
        o = (q > 32767) || (q < -32768);
        if (o && sat) cr = (q < 0) ? 16'h8000 : 16'h7FFF;
        else cr = q[15:0];
        return {cr, o, 1'b0};
    endfunction

    task automatic start_op(input logic [15:0] av, input logic [15:0] bv);
        @(negedge clk);
        in_valid = 1'b1;
        a_in = av;
        b_in = bv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus0.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic ack();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tests_run++;
        if ({bus0.in_ready, bus0.out_valid, bus0.c, bus0.ovf, bus0.dz, bus0.busy} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
            tests_failed++;
            $display("FAIL reset_wrap: got rdy=%b vld=%b c=%h ovf=%b dz=%b busy=%b", bus0.in_ready, bus0.out_valid, bus0.c, bus0.ovf, bus0.dz, bus0.busy);
        end
        tests_run++;
        if ({bus1.in_ready, bus1.out_valid, bus1.c, bus1.ovf, bus1.dz, bus1.busy} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
            tests_failed++;
            $display("FAIL reset_sat: got rdy=%b vld=%b c=%h ovf=%b dz=%b busy=%b", bus1.in_ready, bus1.out_valid, bus1.c, bus1.ovf, bus1.dz, bus1.busy);
        end
    endtask

    task automatic test_basic();
        int lat;
        bit busy_ok;
        start_op(16'h0300, 16'h0200);
        lat = 1;
        busy_ok = 1'b1;
        while (!bus0.out_valid && lat < 200) begin
            if (bus0.busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        tests_run++;
        if (lat !== LAT) begin tests_failed++; $display("FAIL basic_latency: got %0d exp %0d", lat, LAT); end
        tests_run++;
        if (busy_ok !== 1'b1) begin tests_failed++; $display("FAIL basic_busy: busy dropped before result, got %b exp 1", busy_ok); end
        tests_run++;
        if ({bus0.c, bus0.ovf, bus0.dz} !== {16'h0180, 2'b00}) begin
            tests_failed++;
            $display("FAIL basic_result: got c=%h ovf=%b dz=%b exp c=0180 ovf=0 dz=0", bus0.c, bus0.ovf, bus0.dz);
        end
        ack();
        tests_run++;
        if ({bus0.out_valid, bus0.in_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL basic_ack: got vld=%b rdy=%b exp vld=0 rdy=1", bus0.out_valid, bus0.in_ready);
        end
    endtask

    task automatic test_directed();
        logic [15:0] va [12] = '{16'h0300, 16'hFD00, 16'h0100, 16'hFF00, 16'h0000, 16'h7F00,
                                 16'h8000, 16'h8000, 16'h0100, 16'hFF00, 16'h0000, 16'h8000};
        logic [15:0] vb [12] = '{16'h0200, 16'h0200, 16'h0300, 16'h0300, 16'hFF00, 16'h0080,
                                 16'hFF00, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h8000};
        logic [15:0] vc0 [12] = '{16'h0180, 16'hFE80, 16'h0055, 16'hFFAB, 16'h0000, 16'hFE00,
                                  16'h8000, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0100};
        logic [15:0] vc1 [12] = '{16'h0180, 16'hFE80, 16'h0055, 16'hFFAB, 16'h0000, 16'h7FFF,
                                  16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0100};
        logic [1:0] vfl [12] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10,
                                 2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
        int lat, elat;
        for (int i = 0; i < 12; i++) begin
            start_op(va[i], vb[i]);
            wait_done(lat);
            elat = (vb[i] == 16'h0) ? 1 : LAT;
            tests_run++;
            if (lat !== elat) begin tests_failed++; $display("FAIL dir%0d_latency: got %0d exp %0d", i, lat, elat); end
            tests_run++;
            if ({bus0.c, bus0.ovf, bus0.dz} !== {vc0[i], vfl[i]}) begin
                tests_failed++;
                $display("FAIL dir%0d_wrap: a=%h b=%h got c=%h ovf=%b dz=%b exp c=%h fl=%b", i, va[i], vb[i], bus0.c, bus0.ovf, bus0.dz, vc0[i], vfl[i]);
            end
            tests_run++;
            if ({bus1.c, bus1.ovf, bus1.dz} !== {vc1[i], vfl[i]}) begin
                tests_failed++;
                $display("FAIL dir%0d_sat: a=%h b=%h got c=%h ovf=%b dz=%b exp c=%h fl=%b", i, va[i], vb[i], bus1.c, bus1.ovf, bus1.dz, vc1[i], vfl[i]);
            end
            ack();
        end
    endtask

    task automatic test_hold();
        int lat;
        logic [17:0] e;
        e = model(16'h1234, 16'hFA99, 1'b0);
        start_op(16'h1234, 16'hFA99);
        wait_done(lat);
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if ({bus0.out_valid, bus0.in_ready, bus0.c, bus0.ovf, bus0.dz} !== {2'b10, e}) begin
                tests_failed++;
                $display("FAIL hold_cycle%0d: got vld=%b rdy=%b c=%h ovf=%b dz=%b exp vld=1 rdy=0 {c,ovf,dz}=%h", i, bus0.out_valid, bus0.in_ready, bus0.c, bus0.ovf, bus0.dz, e);
            end
            @(posedge clk);
            #1;
        end
        ack();
    endtask

    task automatic test_ignore_busy();
        int lat;
        start_op(16'h0300, 16'h0200);
        repeat (5) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        a_in = 16'h7000;
        b_in = 16'h0100;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tests_run++;
        if (bus0.in_ready !== 1'b0) begin tests_failed++; $display("FAIL ignore_ready: got %b exp 0", bus0.in_ready); end
        wait_done(lat);
        tests_run++;
        if ({bus0.c, bus0.ovf, bus0.dz} !== {16'h0180, 2'b00}) begin
            tests_failed++;
            $display("FAIL ignore_calc: got c=%h ovf=%b dz=%b exp c=0180", bus0.c, bus0.ovf, bus0.dz);
        end
        // An operand offered while the result waits must not start a new operation
        @(negedge clk);
        in_valid = 1'b1;
        a_in = 16'h0100;
        b_in = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        ack();
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({bus0.out_valid, bus0.busy, bus0.in_ready} !== 3'b001) begin
            tests_failed++;
            $display("FAIL ignore_done: got vld=%b busy=%b rdy=%b exp vld=0 busy=0 rdy=1", bus0.out_valid, bus0.busy, bus0.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        start_op(16'h7F00, 16'h0080);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests_run++;
        if ({bus0.in_ready, bus0.out_valid, bus0.c, bus0.busy} !== {2'b10, 16'h0, 1'b0}) begin
            tests_failed++;
            $display("FAIL midreset_state: got rdy=%b vld=%b c=%h busy=%b exp rdy=1 vld=0 c=0000 busy=0", bus0.in_ready, bus0.out_valid, bus0.c, bus0.busy);
        end
        start_op(16'h0300, 16'h0200);
        wait_done(lat);
        tests_run++;
        if ({lat, bus0.c} !== {LAT, 16'h0180}) begin
            tests_failed++;
            $display("FAIL midreset_op: got lat=%0d c=%h exp lat=%0d c=0180", lat, bus0.c, LAT);
        end
        ack();
    endtask

    task automatic test_random();
        logic [15:0] bnd [4] = '{16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF};
        logic [15:0] av, bv;
        logic [17:0] e0, e1;
        int lat, elat;
        for (int i = 0; i < 60; i++) begin
            av = 16'($urandom);
            bv = 16'($urandom);
            case ($urandom_range(0, 7))
                0: bv = 16'h0000;
                1: bv = bnd[$urandom_range(0, 3)];
                2: av = bnd[$urandom_range(0, 3)];
                3: bv = 16'($urandom_range(1, 255));
                default: ;
            endcase
            e0 = model(av, bv, 1'b0);
            e1 = model(av, bv, 1'b1);
            elat = (bv == 16'h0) ? 1 : LAT;
            start_op(av, bv);
            wait_done(lat);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            tests_run++;
            if (lat !== elat) begin tests_failed++; $display("FAIL rnd%0d_latency: a=%h b=%h got %0d exp %0d", i, av, bv, lat, elat); end
            tests_run++;
            if ({bus0.out_valid, bus0.c, bus0.ovf, bus0.dz} !== {1'b1, e0}) begin
                tests_failed++;
                $display("FAIL rnd%0d_wrap: a=%h b=%h got vld=%b c=%h ovf=%b dz=%b exp %h", i, av, bv, bus0.out_valid, bus0.c, bus0.ovf, bus0.dz, e0);
            end
            tests_run++;
            if ({bus1.out_valid, bus1.c, bus1.ovf, bus1.dz} !== {1'b1, e1}) begin
                tests_failed++;
                $display("FAIL rnd%0d_sat: a=%h b=%h got vld=%b c=%h ovf=%b dz=%b exp %h", i, av, bv, bus1.out_valid, bus1.c, bus1.ovf, bus1.dz, e1);
            end
            ack();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_directed();
        test_hold();
        test_ignore_busy();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
